// File: rtl/raddr_channel.sv
// AXI read-address channel walker for a 2-D tile of fixed-size bursts.
// Issues (w1+1)*(h1+1) AR bursts in x-major order with a fixed address stride.
// It limits in-flight bursts with an outstanding-credit counter. The counter is
// released by R-channel last beats, which arrive on monitor-only taps.
module raddr_channel #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int BURST_BYTES     = 896,
  parameter int BURST_LEN       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  input  logic        m_axi_rready,
  input  logic        m_axi_rlast,
  input  logic        start_pulse,
  input  logic [63:0] source_address,
  input  logic [9:0]  w1,
  input  logic [9:0]  h1,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  ISSUE = 2'd1;
  localparam logic [1:0]  DRAIN = 2'd2;

  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [63:0] STRIDE    = 64'(BURST_BYTES);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN);

  logic [1:0]  state;
  logic [63:0] addr_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [9:0]  w1_q;
  logic [9:0]  h1_q;
  logic [3:0]  outstanding;
  logic [7:0]  beat_q;
  logic        presented_q;

  logic        start_accept;
  logic        ar_hs;
  logic        r_beat;
  logic        r_last;

  assign m_axi_arlen  = LAST_BEAT;
  assign m_axi_araddr = addr_q;
  assign busy         = (state != IDLE);

  // Handshake decode; arvalid is combinational so a new request can follow a handshake directly
  always_comb begin
    start_accept  = (state == IDLE) && start_pulse;
    m_axi_arvalid = (state == ISSUE) && ((outstanding < MAX_OUT) || presented_q);
    ar_hs         = m_axi_arvalid && m_axi_arready;
    r_beat        = m_axi_rvalid && m_axi_rready;
    r_last        = r_beat && m_axi_rlast;
  end

  // Walk state machine: x/y position, burst address and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w1_q        <= '0;
      h1_q        <= '0;
      presented_q <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      presented_q <= m_axi_arvalid && !m_axi_arready;
      case (state)
        IDLE: begin
          if (start_pulse) begin
            addr_q <= source_address;
            w1_q   <= w1;
            h1_q   <= h1;
            x_q    <= '0;
            y_q    <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            addr_q <= addr_q + STRIDE;
            if (x_q == w1_q) begin
              x_q <= '0;
              y_q <= y_q + 10'd1;
              if (y_q == h1_q) begin
                state <= DRAIN;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        DRAIN: begin
          if (outstanding == 4'd0) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-burst credit counter; simultaneous issue and completion cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (ar_hs && !r_last) begin
      outstanding <= outstanding + 4'd1;
    end else if (!ar_hs && r_last && (outstanding != 4'd0)) begin
      outstanding <= outstanding - 4'd1;
    end
  end

  // R-beat tracking and sticky protocol-error flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      err    <= 1'b0;
    end else begin
      if (start_accept) begin
        err <= 1'b0;
      end
      if (r_beat) begin
        if (m_axi_rlast) begin
          beat_q <= '0;
          if ((beat_q != LAST_BEAT) || (outstanding == 4'd0)) begin
            err <= 1'b1;
          end
        end else if (beat_q == LAST_BEAT) begin
          beat_q <= '0;
          err    <= 1'b1;
        end else begin
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_raddr_channel.sv
// Directed self-checking bench for raddr_channel with a two-burst credit limit.
module tb_raddr_channel;

  localparam int STRIDE = 896;

  logic        clk;
  logic        rst_n;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axi_rlast;
  logic        start_pulse;
  logic [63:0] source_address;
  logic [9:0]  w1;
  logic [9:0]  h1;
  logic        busy;
  logic        done;
  logic        err;

  int checks_done = 0;
  int fail_count  = 0;

  typedef struct {
    logic [63:0] base;
    logic [9:0]  w1;
    logic [9:0]  h1;
    int          exp_bursts;
    logic [63:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  raddr_channel #(
    .MAX_OUTSTANDING(2),
    .BURST_BYTES(896),
    .BURST_LEN(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_rlast(m_axi_rlast),
    .start_pulse(start_pulse),
    .source_address(source_address),
    .w1(w1),
    .h1(h1),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and log a failure line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_done++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to the next falling edge (one rising edge in between)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic setR(input logic v, input logic last);
    m_axi_rvalid = v;
    m_axi_rready = v;
    m_axi_rlast  = v && last;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Present a one-cycle start with the given walk parameters
  task automatic applyStimulus(input logic [63:0] b, input logic [9:0] xw, input logic [9:0] yh);
    start_pulse    = 1'b1;
    source_address = b;
    w1             = xw;
    h1             = yh;
    step();
    start_pulse    = 1'b0;
  endtask

  // Run a full walk with arready=1 and a responder returning 7-beat bursts
  task automatic runWalk(input logic [63:0] b, input logic [9:0] xw, input logic [9:0] yh,
                         output int n_hs, output int n_done, output int addr_bad,
                         output logic [63:0] last_a);
    int pend = 0;
    int beat = 0;
    int cyc  = 0;
    logic hs;
    n_hs = 0; n_done = 0; addr_bad = 0; last_a = '0;
    m_axi_arready = 1'b1;
    applyStimulus(b, xw, yh);
    while (cyc < 600 && !(n_done > 0 && !busy)) begin
      if (done) n_done++;
      hs = m_axi_arvalid && m_axi_arready;
      if (hs) begin
        if (m_axi_araddr !== b + 64'(n_hs) * 64'(STRIDE)) addr_bad++;
        last_a = m_axi_araddr;
      end
      setR(pend > 0, beat == 6);
      step();
      cyc++;
      if (pend > 0) begin
        if (beat == 6) begin beat = 0; pend--; end
        else beat++;
      end
      if (hs) begin n_hs++; pend++; end
    end
    setR(1'b0, 1'b0);
    if (cyc >= 600) checkOutput("walk_timeout", 64'(cyc), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      step();
    end
  endtask

  initial begin
    int n_hs, n_done, addr_bad, cnt;
    logic [63:0] last_a;
    logic stable;

    vecs[0] = '{64'h1000, 10'd1, 10'd1, 4, 64'h1A80};
    vecs[1] = '{64'h0, 10'd0, 10'd0, 1, 64'h0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FE00, 10'd1, 10'd0, 2, 64'h180};
    vecs[3] = '{64'h2000, 10'd2, 10'd1, 6, 64'h3180};

    rst_n = 1'b0; m_axi_arready = 1'b0; start_pulse = 1'b0;
    source_address = '0; w1 = '0; h1 = '0;
    setR(1'b0, 1'b0);
    step();
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("rst_araddr", m_axi_araddr, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_arlen", 64'(m_axi_arlen), 64'd6);

    $display("[TB] table-driven walks");
    for (int v = 0; v < 4; v++) begin
      runWalk(vecs[v].base, vecs[v].w1, vecs[v].h1, n_hs, n_done, addr_bad, last_a);
      checkOutput($sformatf("v%0d_bursts", v), 64'(n_hs), 64'(vecs[v].exp_bursts));
      checkOutput($sformatf("v%0d_addr_seq", v), 64'(addr_bad), 64'd0);
      checkOutput($sformatf("v%0d_last_addr", v), last_a, vecs[v].exp_last);
      checkOutput($sformatf("v%0d_done_pulses", v), 64'(n_done), 64'd1);
      checkOutput($sformatf("v%0d_err", v), 64'(err), 64'd0);
      checkOutput($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
    end

    $display("[TB] credit limit and simultaneous issue/complete");
    m_axi_arready = 1'b1;
    applyStimulus(64'h0, 10'd4, 10'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_axi_arvalid && m_axi_arready) cnt++;
      step();
    end
    checkOutput("credit_hs_count", 64'(cnt), 64'd2);
    checkOutput("credit_arvalid_low", 64'(m_axi_arvalid), 64'd0);
    m_axi_arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      setR(1'b1, i == 6);
      step();
    end
    setR(1'b0, 1'b0);
    checkOutput("credit_third_arvalid", 64'(m_axi_arvalid), 64'd1);
    checkOutput("credit_third_addr", m_axi_araddr, 64'h700);
    for (int i = 0; i < 6; i++) begin
      setR(1'b1, 1'b0);
      step();
    end
    checkOutput("held_addr_during_r", m_axi_araddr, 64'h700);
    setR(1'b1, 1'b1);
    m_axi_arready = 1'b1;
    step();
    setR(1'b0, 1'b0);
    checkOutput("simul_arvalid", 64'(m_axi_arvalid), 64'd1);
    checkOutput("simul_next_addr", m_axi_araddr, 64'hA80);
    step();
    checkOutput("simul_then_full", 64'(m_axi_arvalid), 64'd0);
    checkOutput("simul_err", 64'(err), 64'd0);
    m_axi_arready = 1'b0;
    doReset();

    $display("[TB] arready stall and early rlast");
    applyStimulus(64'h4000, 10'd0, 10'd0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(m_axi_arvalid === 1'b1 && m_axi_araddr === 64'h4000)) stable = 1'b0;
      step();
    end
    checkOutput("stall_stable", 64'(stable), 64'd1);
    checkOutput("stall_arvalid_6th", 64'(m_axi_arvalid), 64'd1);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    checkOutput("stall_hs_arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("stall_busy_drain", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      setR(1'b1, i == 3);
      step();
    end
    setR(1'b0, 1'b0);
    checkOutput("early_rlast_err", 64'(err), 64'd1);
    step();
    checkOutput("early_done", 64'(done), 64'd1);
    checkOutput("early_idle", 64'(busy), 64'd0);
    step();
    step();
    checkOutput("err_sticky", 64'(err), 64'd1);
    checkOutput("done_single", 64'(done), 64'd0);
    applyStimulus(64'h0, 10'd0, 10'd0);
    checkOutput("err_cleared_start", 64'(err), 64'd0);
    doReset();

    $display("[TB] reset mid-walk");
    m_axi_arready = 1'b1;
    applyStimulus(64'h8000, 10'd3, 10'd3);
    step();
    step();
    rst_n = 1'b0;
    step();
    checkOutput("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_araddr", m_axi_araddr, 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) cnt++;
      step();
    end
    checkOutput("midrst_no_done", 64'(cnt), 64'd0);
    runWalk(vecs[0].base, vecs[0].w1, vecs[0].h1, n_hs, n_done, addr_bad, last_a);
    checkOutput("post_rst_bursts", 64'(n_hs), 64'd4);
    checkOutput("post_rst_addr_seq", 64'(addr_bad), 64'd0);
    checkOutput("post_rst_last", last_a, 64'h1A80);
    checkOutput("post_rst_done", 64'(n_done), 64'd1);
    checkOutput("post_rst_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule

// File: doc/raddr_channel.md
RADDR_CHANNEL -- requirements
Module: raddr_channel

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of AR bursts accepted but not yet completed by an R-channel last beat (range 1..15).
REQ-002 SHALL have parameter BURST_BYTES, default 896, meaning the address stride between consecutive bursts.
REQ-003 SHALL have parameter BURST_LEN, default 6, meaning the value driven on m_axi_arlen (beats per burst = BURST_LEN+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the synchronous, active-low reset.
REQ-006 SHALL have port m_axi_araddr, output, 64, the AXI read address.
REQ-007 SHALL have port m_axi_arlen, output, 8, the burst length, constant BURST_LEN.
REQ-008 SHALL have port m_axi_arvalid, output, 1, the AR valid.
REQ-009 SHALL have port m_axi_arready, input, 1, the AR ready.
REQ-010 SHALL have port m_axi_rvalid, input, 1, the R valid (monitor tap).
REQ-011 SHALL have port m_axi_rready, input, 1, the R ready driven by the data consumer (monitor tap).
REQ-012 SHALL have port m_axi_rlast, input, 1, the R last (monitor tap).
REQ-013 SHALL have port start_pulse, input, 1, a one-cycle request to start a tile walk.
REQ-014 SHALL have port source_address, input, 64, the base address, sampled on an accepted start.
REQ-015 SHALL have ports w1 and h1, input, 10 each, the last x and last y index (inclusive), sampled on an accepted start.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-017 SHALL have port done, output, 1, a one-cycle pulse on walk completion.
REQ-018 SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-019 SHALL implement the states IDLE, ISSUE and DRAIN.
REQ-020 IDLE: start_pulse=1 SHALL latch source_address, w1 and h1, clear x, y and the burst address to the base, clear err, and move to ISSUE on the next cycle; start_pulse SHALL be ignored in ISSUE and DRAIN.
REQ-021 The walk SHALL issue exactly (w1+1)*(h1+1) bursts in x-major order: x increments 0..w1, then wraps to 0 with y+1, up to y=h1.
REQ-022 Burst n SHALL use address base + n*BURST_BYTES, computed modulo 2^64 (wrap-around permitted, no error).
REQ-023 m_axi_arvalid SHALL be 1 in ISSUE only while the outstanding count is < MAX_OUTSTANDING, or while a request is already presented.
REQ-024 Once m_axi_arvalid is asserted, it and m_axi_araddr SHALL be held stable until a cycle with m_axi_arready=1.
REQ-025 An AR handshake (arvalid & arready) SHALL advance x/y and the address in the same edge; a handshake on burst x=w1, y=h1 SHALL move the state to DRAIN.
REQ-026 The outstanding counter SHALL increment on an AR handshake and decrement on rvalid & rready & rlast; when both occur in the same cycle it SHALL be unchanged.
REQ-027 A beat counter SHALL count rvalid & rready beats per burst; rlast on a beat other than beat BURST_LEN, a missing rlast on beat BURST_LEN, or rlast with outstanding=0 SHALL set err (sticky until the next accepted start or reset); the outstanding counter SHALL NOT underflow.
REQ-028 DRAIN: when outstanding=0, the block SHALL pulse done for exactly one cycle and return to IDLE in the same edge.
REQ-029 The combinational latency from an AR handshake to the next arvalid SHALL be 0 cycles (back-to-back issue allowed when credit remains).
REQ-030 w1=0, h1=0 SHALL produce exactly one burst.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear m_axi_arvalid, m_axi_araddr, busy, done, err and all counters to 0; m_axi_arlen SHALL remain BURST_LEN.
REQ-032 A reset mid-walk SHALL abandon the walk and any outstanding bursts without asserting done.

Verification
REQ-033 base=0x1000, w1=1, h1=1, arready=1, R returns 7 beats per burst -> addresses 0x1000, 0x1380, 0x1700, 0x1A80; one done pulse; err=0.
REQ-034 MAX_OUTSTANDING=2, w1=4, h1=0, no R beats -> exactly 2 handshakes, then arvalid=0; after one rlast, a third AR is issued.
REQ-035 arready held low for 5 cycles -> arvalid and araddr stable for all 5 cycles; the handshake occurs on the 6th cycle.
REQ-036 rlast on beat 3 -> err=1 and stays 1 until the next start.
REQ-037 AR handshake and rlast in the same cycle -> outstanding unchanged; base=0xFFFF_FFFF_FFFF_FE00, w1=1 -> second address 0x0000_0000_0000_0180.
REQ-038 rst_n=0 in the middle of ISSUE -> arvalid=0 and busy=0 on the next edge; no done pulse; a new start works normally.
